// File: rtl/wb_commit_unit_if.sv
// Handshake and register-file write-port bundle for wb_commit_unit.
//   issue_*  : decode issue request and scoreboard ready
//   alu_*    : ALU result stream (valid/ready)
//   ld_*     : cache load result stream (valid only, never stalled)
//   rf_*     : registered register-file write port (write, addr3, data3)
// The slave modport is the commit unit's view; the master modport is the
// view of the surrounding pipeline.
interface wb_commit_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REG   = 4
);
  localparam int AW = $clog2(NUM_REG);

  logic                 issue_valid;
  logic [AW-1:0]        issue_dest;
  logic                 issue_ready;
  logic                 alu_valid;
  logic                 alu_ready;
  logic [AW-1:0]        alu_dest;
  logic [WORD_SIZE-1:0] alu_data;
  logic                 ld_valid;
  logic [AW-1:0]        ld_dest;
  logic [WORD_SIZE-1:0] ld_data;
  logic                 rf_write;
  logic [AW-1:0]        rf_addr;
  logic [WORD_SIZE-1:0] rf_data;

  modport slave (
    input  issue_valid, issue_dest,
    output issue_ready,
    input  alu_valid, alu_dest, alu_data,
    output alu_ready,
    input  ld_valid, ld_dest, ld_data,
    output rf_write, rf_addr, rf_data
  );

  modport master (
    output issue_valid, issue_dest,
    input  issue_ready,
    output alu_valid, alu_dest, alu_data,
    input  alu_ready,
    output ld_valid, ld_dest, ld_data,
    input  rf_write, rf_addr, rf_data
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage in front of the register-file write port.
// Arbitrates load results (highest priority), a one-entry ALU skid
// register, and direct ALU results onto a registered write port, and keeps
// a per-register pending scoreboard for decode.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : wb_commit_unit_if.slave (issue, alu, ld, rf write port)
//   pending  : registered scoreboard, bit i = register i awaiting writeback
//   busy     : skid occupied, write in flight, or any register pending
module wb_commit_unit #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REG   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_commit_unit_if.slave    bus,
  output logic [NUM_REG-1:0] pending,
  output logic               busy
);
  localparam int AW = $clog2(NUM_REG);

  logic                 skid_valid, skid_valid_d;
  logic [AW-1:0]        skid_dest, skid_dest_d;
  logic [WORD_SIZE-1:0] skid_data, skid_data_d;

  logic                 rf_write_q, rf_write_d;
  logic [AW-1:0]        rf_addr_q, rf_addr_d;
  logic [WORD_SIZE-1:0] rf_data_q, rf_data_d;

  logic [NUM_REG-1:0]   pending_d;
  logic                 alu_acc;

  assign bus.alu_ready   = ~skid_valid;
  assign bus.issue_ready = ~pending[bus.issue_dest];
  assign alu_acc         = bus.alu_valid & ~skid_valid;

  assign bus.rf_write = rf_write_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_data  = rf_data_q;
  assign busy         = skid_valid | rf_write_q | (|pending);

  always_comb begin
    rf_write_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    skid_valid_d = skid_valid;
    skid_dest_d  = skid_dest;
    skid_data_d  = skid_data;
    pending_d    = pending;

    // Commit clears before issue sets: issue_ready guarantees the two never
    // target a pending register together, and an unscoreboarded write must
    // not cancel a fresh issue to the same register.
    if (rf_write_q)
      pending_d[rf_addr_q] = 1'b0;
    if (bus.issue_valid && bus.issue_ready)
      pending_d[bus.issue_dest] = 1'b1;

    if (bus.ld_valid) begin
      rf_write_d = 1'b1;
      rf_addr_d  = bus.ld_dest;
      rf_data_d  = bus.ld_data;
      if (alu_acc) begin
        skid_valid_d = 1'b1;
        skid_dest_d  = bus.alu_dest;
        skid_data_d  = bus.alu_data;
      end
    end else if (skid_valid) begin
      rf_write_d   = 1'b1;
      rf_addr_d    = skid_dest;
      rf_data_d    = skid_data;
      skid_valid_d = 1'b0;
    end else if (alu_acc) begin
      rf_write_d = 1'b1;
      rf_addr_d  = bus.alu_dest;
      rf_data_d  = bus.alu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid <= 1'b0;
      skid_dest  <= '0;
      skid_data  <= '0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      pending    <= '0;
    end else begin
      skid_valid <= skid_valid_d;
      skid_dest  <= skid_dest_d;
      skid_data  <= skid_data_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      pending    <= pending_d;
    end
  end
endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] pending;
  logic       busy;

  int tests = 0;
  int fails = 0;

  wb_commit_unit_if bus ();

  wb_commit_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .pending (pending),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: a FIFO of ALU results waiting behind loads, a
  // per-register pending array and the last committed write.
  logic [17:0] backlog[$];
  logic        m_write;
  logic [1:0]  m_addr;
  logic [15:0] m_data;
  logic [3:0]  m_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_write <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      m_pend  <= '0;
      backlog.delete();
    end else begin
      logic        take_alu;
      logic [3:0]  np;
      logic [17:0] e;
      take_alu = bus.alu_valid && (backlog.size() == 0);
      np = m_pend;
      if (m_write) np[m_addr] = 1'b0;
      if (bus.issue_valid && !m_pend[bus.issue_dest]) np[bus.issue_dest] = 1'b1;
      if (bus.ld_valid) begin
        m_write <= 1'b1; m_addr <= bus.ld_dest; m_data <= bus.ld_data;
        if (take_alu) backlog.push_back({bus.alu_dest, bus.alu_data});
      end else if (backlog.size() != 0) begin
        e = backlog.pop_front();
        m_write <= 1'b1; m_addr <= e[17:16]; m_data <= e[15:0];
      end else if (take_alu) begin
        m_write <= 1'b1; m_addr <= bus.alu_dest; m_data <= bus.alu_data;
      end else begin
        m_write <= 1'b0;
      end
      m_pend <= np;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_rf_write", {31'b0, bus.rf_write}, {31'b0, m_write});
    chk("m_rf_addr", {30'b0, bus.rf_addr}, {30'b0, m_addr});
    chk("m_rf_data", {16'b0, bus.rf_data}, {16'b0, m_data});
    chk("m_pending", {28'b0, pending}, {28'b0, m_pend});
    chk("m_alu_ready", {31'b0, bus.alu_ready}, {31'b0, backlog.size() == 0});
    chk("m_busy", {31'b0, busy}, {31'b0, (backlog.size() != 0) || m_write || (m_pend != 0)});
    chk("m_issue_ready", {31'b0, bus.issue_ready}, {31'b0, !m_pend[bus.issue_dest]});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_dest = 0;
    bus.alu_valid = 0; bus.alu_dest = 0; bus.alu_data = 0;
    bus.ld_valid = 0; bus.ld_dest = 0; bus.ld_data = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    idle();
    cyc(); cyc();
    chk("rst_rf_write", {31'b0, bus.rf_write}, 0);
    chk("rst_rf_addr", {30'b0, bus.rf_addr}, 0);
    chk("rst_rf_data", {16'b0, bus.rf_data}, 0);
    chk("rst_pending", {28'b0, pending}, 0);
    chk("rst_alu_ready", {31'b0, bus.alu_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    reset_n = 1;
    cyc();

    // Issue r2, ALU result r2 = 1234 next cycle
    bus.issue_valid = 1; bus.issue_dest = 2;
    cyc();
    chk("t2_pend_set", {28'b0, pending}, 32'h4);
    chk("t2_issue_ready", {31'b0, bus.issue_ready}, 0);
    bus.issue_valid = 0;
    bus.alu_valid = 1; bus.alu_dest = 2; bus.alu_data = 16'h1234;
    cyc();
    idle();
    chk("t2_write", {31'b0, bus.rf_write}, 1);
    chk("t2_addr", {30'b0, bus.rf_addr}, 2);
    chk("t2_data", {16'b0, bus.rf_data}, 32'h1234);
    chk("t2_pend_held", {28'b0, pending}, 32'h4);
    cyc();
    chk("t2_pend_clr", {28'b0, pending}, 0);
    chk("t2_idle_busy", {31'b0, busy}, 0);

    // Issue r1, r3; then ld r1 BEEF with alu r3 0007 together
    bus.issue_valid = 1; bus.issue_dest = 1;
    cyc();
    bus.issue_dest = 3;
    cyc();
    chk("t3_pend", {28'b0, pending}, 32'ha);
    idle();
    bus.ld_valid = 1; bus.ld_dest = 1; bus.ld_data = 16'hBEEF;
    bus.alu_valid = 1; bus.alu_dest = 3; bus.alu_data = 16'h0007;
    cyc();
    idle();
    chk("t3_ld_addr", {30'b0, bus.rf_addr}, 1);
    chk("t3_ld_data", {16'b0, bus.rf_data}, 32'hBEEF);
    chk("t3_alu_ready0", {31'b0, bus.alu_ready}, 0);
    cyc();
    chk("t3_skid_addr", {30'b0, bus.rf_addr}, 3);
    chk("t3_skid_data", {16'b0, bus.rf_data}, 32'h0007);
    chk("t3_pend_r1clr", {28'b0, pending}, 32'h8);
    chk("t3_alu_ready1", {31'b0, bus.alu_ready}, 1);
    cyc();
    chk("t3_pend_zero", {28'b0, pending}, 0);

    // Skid filled, then two consecutive loads r0 = AAAA starve it
    bus.ld_valid = 1; bus.ld_dest = 1; bus.ld_data = 16'h1111;
    bus.alu_valid = 1; bus.alu_dest = 2; bus.alu_data = 16'h5555;
    cyc();
    bus.alu_valid = 0;
    bus.ld_dest = 0; bus.ld_data = 16'hAAAA;
    chk("t4_skid_full", {31'b0, bus.alu_ready}, 0);
    cyc();
    chk("t4_ld1", {14'b0, bus.rf_addr, bus.rf_data}, 32'h0AAAA);
    chk("t4_ready_a", {31'b0, bus.alu_ready}, 0);
    cyc();
    idle();
    chk("t4_ld2", {14'b0, bus.rf_addr, bus.rf_data}, 32'h0AAAA);
    chk("t4_ready_b", {31'b0, bus.alu_ready}, 0);
    cyc();
    chk("t4_skid_out", {14'b0, bus.rf_addr, bus.rf_data}, 32'h25555);
    chk("t4_ready_c", {31'b0, bus.alu_ready}, 1);
    cyc();

    // Re-issue to a pending register is held off until commit
    bus.issue_valid = 1; bus.issue_dest = 2;
    cyc();
    #1;
    chk("t5_ready_low", {31'b0, bus.issue_ready}, 0);
    cyc();
    chk("t5_pend_same", {28'b0, pending}, 32'h4);
    bus.alu_valid = 1; bus.alu_dest = 2; bus.alu_data = 16'h0F0F;
    cyc();
    bus.alu_valid = 0;
    chk("t5_write", {14'b0, bus.rf_addr, bus.rf_data}, 32'h20F0F);
    cyc();
    chk("t5_ready_high", {31'b0, bus.issue_ready}, 1);
    chk("t5_pend_clr", {28'b0, pending}, 0);
    cyc();
    bus.issue_valid = 0;
    chk("t5_reissue", {28'b0, pending}, 32'h4);
    bus.alu_valid = 1; bus.alu_dest = 2; bus.alu_data = 16'h0002;
    cyc();
    idle();
    cyc(); cyc();

    // Unscoreboarded write to r0
    bus.alu_valid = 1; bus.alu_dest = 0; bus.alu_data = 16'h00C3;
    cyc();
    idle();
    chk("t6_write", {14'b0, bus.rf_addr, bus.rf_data}, 32'h000C3);
    chk("t6_pend", {28'b0, pending}, 0);
    chk("t6_busy1", {31'b0, busy}, 1);
    cyc();
    chk("t6_busy0", {31'b0, busy}, 0);

    // Reset mid-cycle with skid full and a register pending
    bus.issue_valid = 1; bus.issue_dest = 3;
    cyc();
    idle();
    bus.ld_valid = 1; bus.ld_dest = 3; bus.ld_data = 16'hFACE;
    bus.alu_valid = 1; bus.alu_dest = 1; bus.alu_data = 16'h0001;
    cyc();
    chk("t7_pre_skid", {31'b0, bus.alu_ready}, 0);
    chk("t7_pre_pend", {28'b0, pending}, 32'h8);
    reset_n = 0;
    idle();
    #1;
    chk("t7_rst_write", {31'b0, bus.rf_write}, 0);
    chk("t7_rst_pend", {28'b0, pending}, 0);
    chk("t7_rst_ready", {31'b0, bus.alu_ready}, 1);
    chk("t7_rst_busy", {31'b0, busy}, 0);
    cyc(); cyc();
    reset_n = 1;
    cyc();
    chk("t7_rel_write", {31'b0, bus.rf_write}, 0);
    cyc();
    chk("t7_rel_write2", {31'b0, bus.rf_write}, 0);
    chk("t7_rel_pend", {28'b0, pending}, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Writeback/commit stage sitting directly upstream of the 4x16-bit register file's write port (write, addr3, data3). It accepts ALU results and late-arriving cache load results, arbitrates them onto the single register-file write port through registered outputs, and keeps a per-register pending scoreboard that decode uses to stall on outstanding destinations.

## Interface
- WORD_SIZE, 16, datapath width
- NUM_REG, 4, architectural registers; register address width is 2

- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode issues an instruction that writes issue_dest
- issue_dest  in  2  destination register of issued instruction
- issue_ready  out  1  combinational; = ~pending[issue_dest]
- alu_valid  in  1  ALU result present
- alu_ready  out  1  = ~skid_valid; ALU result accepted when alu_valid & alu_ready
- alu_dest  in  2  ALU result destination
- alu_data  in  16  ALU result value
- ld_valid  in  1  cache load result present; always accepted, no backpressure
- ld_dest  in  2  load destination
- ld_data  in  16  load value
- rf_write  out  1  registered; drives RF write
- rf_addr  out  2  registered; drives RF addr3
- rf_data  out  16  registered; drives RF data3
- pending  out  4  registered scoreboard, bit i = register i awaiting writeback
- busy  out  1  = skid_valid | rf_write | (pending != 0)

## Operation
- Issue: on edge with issue_valid & issue_ready, set pending[issue_dest]. Issue with issue_ready low is ignored (decode must hold).
- Sources per cycle, fixed priority: ld (direct) > skid entry > alu (direct).
- Output register loads the highest-priority valid source each edge; rf_write = 1 for that cycle, else rf_write = 0 and rf_addr/rf_data hold last values.
- Skid register (one entry: dest, data): captures accepted ALU result when ld_valid same cycle. alu_ready = ~skid_valid, so at most one ALU result is parked.
- With skid_valid and no ld_valid: skid drains to output, skid_valid clears.
- With skid_valid and ld_valid: load written, skid held.
- Commit: on edge where rf_write = 1, pending[rf_addr] clears (same edge RF updates).
- Issue and commit to same register in same cycle cannot collide: issue_ready is low while that bit is set.
- Result for a register whose pending bit is 0 is still written; scoreboard unchanged.
- No reordering beyond the skid; WAW is excluded by issue_ready.

## Timing
- Reset (async, reset_n = 0): rf_write = 0, rf_addr = 0, rf_data = 0, pending = 4'b0000, skid_valid = 0, alu_ready = 1, busy = 0. Reset mid-operation drops skid and any in-flight write; no RF write occurs during or on the edge of reset release.
- Load accepted at edge A: rf_write high in cycle A..A+1, RF and pending updated at edge A+1 (latency 1).
- ALU accepted at edge A without ld: same latency 1.
- ALU accepted at edge A with ld: skid at A, output at A+1 (after load), RF/pending at A+2.
- Back-to-back loads every cycle starve the skid; cache guarantees a gap at least every 4 cycles.
- Issue at edge E: pending visible from cycle after E; issue_ready for that dest low from then until commit edge.

## Test plan
- Reset: assert reset_n = 0 mid-cycle with skid full -> outputs immediately rf_write = 0, pending = 0, alu_ready = 1; no write after release.
- Issue r2, ALU result r2 = 16'h1234 next cycle -> following cycle rf_write = 1, rf_addr = 2, rf_data = 16'h1234; pending[2] clears on that edge.
- Issue r1 and r3; same cycle ld r1 = 16'hBEEF and alu r3 = 16'h0007 -> cycle+1 writes r1/BEEF, alu_ready = 0; cycle+2 writes r3/0007; pending = 0 afterwards.
- Skid full plus ld r0 = 16'hAAAA for two consecutive cycles -> both loads written first, skid entry written third cycle, alu_ready low throughout then 1.
- Issue r2 while pending[2] = 1 -> issue_ready = 0, pending unchanged; after commit of r2 issue_ready = 1 and re-issue sets pending[2].
- ALU result to r0 with pending[0] = 0 -> r0 written, pending stays 0, busy returns 0 one cycle later.
